// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: one outstanding access to a 64-bit-wide data memory.
// Loads and stores work at byte, half and word size with misalignment and range checks.
module rv32i_lsu #(
    parameter int MEM_SIZE  = 4096,
    parameter int MEM_WIDTH = $clog2(MEM_SIZE)
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_rdata,
    output logic [1:0]           resp_err,
    output logic [MEM_WIDTH-1:0] mem_addr,
    input  logic [63:0]          mem_rd_data,
    output logic [63:0]          mem_wr_data,
    output logic                 mem_wr_en
);

    localparam int AW = MEM_WIDTH + 3;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state_q, state_d;
    logic          req_ready_q, req_ready_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic [1:0]    resp_err_q, resp_err_d;
    logic          mem_wr_en_q, mem_wr_en_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          unsigned_q, unsigned_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;

    logic [1:0]    req_err;
    logic [2:0]    lane;
    logic [5:0]    shamt;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   word_sel;
    logic [31:0]   load_data;
    logic [63:0]   lane_mask;
    logic [63:0]   wdata_shifted;

    // Illegal size outranks misalignment, which outranks out-of-range.
    always_comb begin
        req_err = 2'b00;
        if (req_size == 2'b11) begin
            req_err = 2'b11;
        end else if ((req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00)) begin
            req_err = 2'b01;
        end else if ((req_addr >> AW) != 32'd0) begin
            req_err = 2'b10;
        end
    end

    assign lane     = addr_q[2:0];
    assign shamt    = {lane, 3'b000};
    assign byte_sel = mem_rd_data[shamt +: 8];
    assign half_sel = mem_rd_data[{lane[2:1], 4'b0000} +: 16];
    assign word_sel = mem_rd_data[{lane[2], 5'b00000} +: 32];

    always_comb begin
        load_data = word_sel;
        lane_mask = 64'h0000_0000_FFFF_FFFF;
        case (size_q)
            2'b00: begin
                load_data = unsigned_q ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
                lane_mask = 64'h0000_0000_0000_00FF;
            end
            2'b01: begin
                load_data = unsigned_q ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
                lane_mask = 64'h0000_0000_0000_FFFF;
            end
            default: begin
                load_data = word_sel;
                lane_mask = 64'h0000_0000_FFFF_FFFF;
            end
        endcase
    end

    // Read-modify-write: only the addressed bytes of the current word change.
    assign wdata_shifted = {32'd0, wdata_q} << shamt;
    assign mem_wr_data   = (mem_rd_data & ~(lane_mask << shamt)) |
                           (wdata_shifted & (lane_mask << shamt));

    always_comb begin
        state_d      = state_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_wr_en_d  = 1'b0;
        we_d         = we_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d         = req_we;
                    size_d       = req_size;
                    unsigned_d   = req_unsigned;
                    addr_d       = req_addr[AW-1:0];
                    wdata_d      = req_wdata;
                    resp_rdata_d = 32'd0;
                    resp_err_d   = req_err;
                    if (req_err != 2'b00) begin
                        resp_valid_d = 1'b1;
                        state_d      = RESP;
                    end else begin
                        mem_wr_en_d = req_we;
                        state_d     = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    resp_rdata_d = load_data;
                end
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_rdata_d = 32'd0;
                    resp_err_d   = 2'b00;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 2'b00;
            mem_wr_en_q  <= 1'b0;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_wr_en_q  <= mem_wr_en_d;
            we_q         <= we_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_wr_en  = mem_wr_en_q;
    assign mem_addr   = addr_q[AW-1:3];

endmodule

// File: doc/rv32i_lsu.md
RV32I_LSU -- requirements
Module: rv32i_lsu

Interface
REQ-001 Parameter MEM_SIZE, default 4096, number of 64-bit data-memory words.
REQ-002 Parameter MEM_WIDTH, default $clog2(MEM_SIZE), memory word-address width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 aresetn  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  core access request.
REQ-006 req_ready  output  1  LSU can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-aligned.
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  core accepts response.
REQ-014 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-015 resp_err  output  2  00 ok, 01 misaligned, 10 out of range, 11 illegal size.
REQ-016 mem_addr  output  MEM_WIDTH  word address to data memory, shared by read and write ports.
REQ-017 mem_rd_data  input  64  asynchronous read data for mem_addr.
REQ-018 mem_wr_data  output  64  merged store word.
REQ-019 mem_wr_en  output  1  write strobe, captured by memory on next rising edge.

Function
REQ-020 The FSM SHALL have states IDLE, ACCESS and RESP; req_ready=1 only in IDLE.
REQ-021 In IDLE, req_valid=1 SHALL latch req_we/size/unsigned/addr/wdata; the FSM SHALL move to RESP with an error code if one applies, else to ACCESS.
REQ-022 Error priority SHALL be illegal size (11) > misaligned (01) > out of range (10).
REQ-023 Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
REQ-024 Out of range: any of addr[31:MEM_WIDTH+3] nonzero.
REQ-025 mem_addr SHALL equal latched addr[MEM_WIDTH+2:3] at all times; byte lane = addr[2:0], little-endian; byte k occupies bits 8k+7:8k.
REQ-026 ACCESS for a load SHALL register the selected byte/half/word from mem_rd_data, sign- or zero-extended to 32 bits, into resp_rdata, then go to RESP.
REQ-027 ACCESS for a store SHALL assert mem_wr_en for exactly that one cycle with mem_wr_data = mem_rd_data, with only the addressed 1/2/4 bytes replaced by req_wdata[7:0]/[15:0]/[31:0]; then go to RESP.
REQ-028 mem_wr_en SHALL never assert outside ACCESS, or for errored or load requests.
REQ-029 RESP SHALL hold resp_valid=1 and keep resp_rdata/resp_err stable until resp_ready=1, then go to IDLE.
REQ-030 Latency SHALL be: ok request accepted at edge N gives resp_valid from cycle N+2; errored request gives resp_valid from cycle N+1.
REQ-031 At most one request SHALL be outstanding; req_valid outside IDLE SHALL be ignored.

Reset
REQ-032 aresetn=0 SHALL immediately force state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=00, mem_wr_en=0 and all latched request fields to 0, including mid-ACCESS and mid-RESP.
REQ-033 The first request after aresetn rises SHALL be accepted on the first rising edge with req_valid=1.

Verification
REQ-034 Word 0 = 0x1122334455667788; store byte 0xAB at addr 0x5 -> single mem_wr_en pulse, word 0 = 0x1122AB4455667788, resp_err=00, resp_rdata=0.
REQ-035 Then load byte addr 0x5 signed -> 0xFFFFFFAB; unsigned -> 0x000000AB; load half signed at addr 0x6 -> 0x00001122; each with resp_valid at N+2.
REQ-036 Store word 0xDEADBEEF at addr 0xC over word 1 = 0 -> word 1 = 0xDEADBEEF00000000; load word at 0xC -> 0xDEADBEEF.
REQ-037 Load word at addr 0x2 -> resp_err=01 at N+1, no mem_wr_en; size=11 at addr 0x3 -> resp_err=11; addr 0x0010_0000 with MEM_SIZE=4096 -> resp_err=10.
REQ-038 resp_ready held 0 for 3 cycles -> resp_valid and resp_rdata stable, req_ready=0, new req_valid ignored; response retires on the cycle resp_ready=1.
REQ-039 aresetn pulsed low during a store's ACCESS cycle -> mem_wr_en drops immediately, state IDLE; a new request is accepted after release.
